flag_interrupt_unit: RTL and testbench
======================================

Name: flag_interrupt_unit

Overview:
- Owns the architectural C, Z and interrupt-enable (I) flags plus their interrupt shadow copies.
- Feeds C and Z directly to the branch calculator in the branch-resolve stage.
- Sequences interrupt entry: stall fetch, wait for the pipeline to drain, save flags, clear I, emit a one-cycle PC redirect to the interrupt vector.
- Restores the flags on RETID/RETIE commit.

Parameters:
- PC_WIDTH, 10, width of the redirect vector output.
- INT_VECTOR, 10'h3FF, PC loaded on interrupt entry.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST_N  in  1  reset; synchronous, active-low.
- C_IN  in  1  carry result from the ALU/writeback.
- Z_IN  in  1  zero result from the ALU/writeback.
- FLG_C_LD  in  1  load C from C_IN.
- FLG_Z_LD  in  1  load Z from Z_IN.
- FLG_C_SET  in  1  SEC.
- FLG_C_CLR  in  1  CLC.
- I_SET  in  1  SEI.
- I_CLR  in  1  CLI.
- RET_COMMIT  in  1  a return-class instruction commits this cycle.
- BRANCH_TYPE  in  4  branch code of the committing instruction: 8 = RETID, 9 = RETIE, others ignored here.
- INTR  in  1  external interrupt request, level-sensitive.
- PIPE_DRAINED  in  1  hazard unit reports no instructions in flight past fetch.
- C_OUT  out  1  carry to the branch calculator.
- Z_OUT  out  1  zero to the branch calculator.
- I_OUT  out  1  registered interrupt enable.
- INT_STALL  out  1  freeze fetch/issue during interrupt entry.
- INT_REDIRECT  out  1  one-cycle pulse: PC <= INT_VECTOR_OUT.
- INT_VECTOR_OUT  out  PC_WIDTH  constant INT_VECTOR.

Behaviour:
- Reset (RST_N = 0 at an edge):
  - C, Z, I, SHAD_C, SHAD_Z <= 0; FSM <= IDLE.
  - INT_STALL = 0, INT_REDIRECT = 0.
  - Reset mid-DRAIN or mid-ENTER aborts entry; no redirect is issued.
- C update priority, highest first:
  - RETID/RETIE restore (C <= SHAD_C)
  - FLG_C_CLR (C <= 0)
  - FLG_C_SET (C <= 1)
  - FLG_C_LD (C <= C_IN)
  - otherwise hold.
- Z update priority, highest first:
  - restore (Z <= SHAD_Z)
  - FLG_Z_LD (Z <= Z_IN)
  - otherwise hold.
- Restore = RET_COMMIT && (BRANCH_TYPE == 4'h8 || BRANCH_TYPE == 4'h9). RET_COMMIT with any other BRANCH_TYPE (e.g. 7, RET) leaves the flags unchanged.
- I update priority, highest first:
  - ENTER state: I <= 0
  - RETID: I <= 0
  - RETIE: I <= 1
  - I_CLR: I <= 0
  - I_SET: I <= 1
  - otherwise hold.
- FSM states IDLE, DRAIN, ENTER:
  - IDLE: INTR && I (registered) -> DRAIN. A RETIE committing this cycle takes effect only from the next cycle.
  - DRAIN: INT_STALL = 1. Stay while !PIPE_DRAINED; PIPE_DRAINED -> ENTER. Deasserting INTR in DRAIN does not cancel entry.
  - ENTER: INT_STALL = 1, INT_REDIRECT = 1 (exactly one cycle). At the edge: SHAD_C <= C, SHAD_Z <= Z, I <= 0; flag-write inputs are ignored. Always -> IDLE.
- Latency: INTR to INT_REDIRECT is at least 2 cycles (1 IDLE->DRAIN, then at least 1 in DRAIN, then ENTER). Once PIPE_DRAINED is asserted, INT_REDIRECT follows 1 cycle later.
- A second INTR while in ENTER, or in the cycle after, is not taken, because I = 0.
- I_OUT is always the registered value.

Optional Feature:
- FLAG_BYPASS_EN
  - Defined: C_OUT/Z_OUT combinationally forward the same-cycle update (including SET/CLR and restore) using the same priority rules, so a branch in the cycle after the ALU op resolves correctly.
  - Undefined: C_OUT/Z_OUT are the registered flags only, and the hazard unit must insert one stall cycle between a flag write and a dependent branch.

Test Plan:
- Reset: drive all inputs to 1, hold RST_N = 0 for 1 edge -> C_OUT = Z_OUT = I_OUT = 0, INT_STALL = 0, INT_REDIRECT = 0.
- Flag priority: FLG_C_SET = FLG_C_CLR = FLG_C_LD = 1 with C_IN = 1 -> next cycle C_OUT = 0. With FLAG_BYPASS_EN: FLG_C_LD = 1, C_IN = 1 -> C_OUT = 1 in the same cycle.
- Interrupt entry: I = 1, C = 1, Z = 0; assert INTR, hold PIPE_DRAINED = 0 for 3 cycles then 1 -> INT_STALL high for 5 cycles; a single INT_REDIRECT pulse with INT_VECTOR_OUT = 10'h3FF; afterwards I_OUT = 0, SHAD_C = 1, SHAD_Z = 0.
- RETIE restore: after entry, set C = 0, Z = 1 via loads; RET_COMMIT = 1, BRANCH_TYPE = 9 -> C_OUT = 1, Z_OUT = 0, I_OUT = 1. Repeat with BRANCH_TYPE = 8 -> I_OUT = 0. BRANCH_TYPE = 7 -> no flag change.
- Masked interrupt: I = 0, INTR = 1 for 10 cycles -> INT_STALL stays 0, no redirect. Then I_SET -> DRAIN entered on the following cycle.
- Reset mid-DRAIN: RST_N = 0 while in DRAIN -> IDLE, INT_STALL = 0, no INT_REDIRECT for the next 5 cycles even with PIPE_DRAINED = 1.

Source files
------------

// File: rtl/flag_interrupt_unit.sv
// flag_interrupt_unit
//
// Holds the architectural carry (C), zero (Z) and interrupt-enable (I) flags,
// plus the shadow copies of C and Z saved on interrupt entry. C and Z go
// straight to the branch calculator. An interrupt is entered in three steps:
//   1. stall fetch
//   2. wait for the pipeline to drain
//   3. save the flags, clear I and pulse a one-cycle redirect to INT_VECTOR
// RETID/RETIE commits restore C and Z from the shadows.
// RETID leaves I cleared; RETIE sets it.
//
// Optional feature macro: FLAG_BYPASS_EN
//   defined   : c_out/z_out forward this cycle's flag update combinationally
//   undefined : c_out/z_out are the registered flags only
//
// Ports:
//   clk            in   clock, all state changes on the rising edge
//   rst_n          in   synchronous active-low reset
//   c_in, z_in     in   carry / zero results from the ALU/writeback
//   flg_c_ld       in   load C from c_in
//   flg_z_ld       in   load Z from z_in
//   flg_c_set      in   SEC
//   flg_c_clr      in   CLC
//   i_set, i_clr   in   SEI / CLI
//   ret_commit     in   a return-class instruction commits this cycle
//   branch_type    in   branch code of the committing instruction (8 RETID, 9 RETIE)
//   intr           in   level-sensitive interrupt request
//   pipe_drained   in   nothing in flight past fetch
//   c_out, z_out   out  flags to the branch calculator
//   i_out          out  registered interrupt enable
//   int_stall      out  freeze fetch/issue during interrupt entry
//   int_redirect   out  one-cycle pulse: load PC from int_vector_out
//   int_vector_out out  interrupt vector (constant)

module flag_interrupt_unit #(
    parameter int                  PC_WIDTH   = 10,
    parameter logic [PC_WIDTH-1:0] INT_VECTOR = PC_WIDTH'(10'h3FF)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                c_in,
    input  logic                z_in,
    input  logic                flg_c_ld,
    input  logic                flg_z_ld,
    input  logic                flg_c_set,
    input  logic                flg_c_clr,
    input  logic                i_set,
    input  logic                i_clr,
    input  logic                ret_commit,
    input  logic [3:0]          branch_type,
    input  logic                intr,
    input  logic                pipe_drained,
    output logic                c_out,
    output logic                z_out,
    output logic                i_out,
    output logic                int_stall,
    output logic                int_redirect,
    output logic [PC_WIDTH-1:0] int_vector_out
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        ENTER = 2'd2
    } state_t;

    localparam logic [3:0] BR_RETID = 4'h8;
    localparam logic [3:0] BR_RETIE = 4'h9;

    state_t state;
    logic   c_flag;
    logic   z_flag;
    logic   i_flag;
    logic   shad_c;
    logic   shad_z;

    logic   is_retid;
    logic   is_retie;
    logic   restore;
    logic   entering;
    logic   c_next;
    logic   z_next;
    logic   i_next;

    assign is_retid = ret_commit && (branch_type == BR_RETID);
    assign is_retie = ret_commit && (branch_type == BR_RETIE);
    assign restore  = is_retid || is_retie;
    assign entering = (state == ENTER);

    // Next-value logic for the flags. While in ENTER, every flag-write
    // input is ignored, so the values saved into the shadows are exactly
    // the ones the interrupted code left behind.
    always_comb begin
        c_next = c_flag;
        z_next = z_flag;
        i_next = i_flag;

        if (entering) begin
            c_next = c_flag;
            z_next = z_flag;
            i_next = 1'b0;
        end else begin
            if (restore)
                c_next = shad_c;
            else if (flg_c_clr)
                c_next = 1'b0;
            else if (flg_c_set)
                c_next = 1'b1;
            else if (flg_c_ld)
                c_next = c_in;

            if (restore)
                z_next = shad_z;
            else if (flg_z_ld)
                z_next = z_in;

            if (is_retid)
                i_next = 1'b0;
            else if (is_retie)
                i_next = 1'b1;
            else if (i_clr)
                i_next = 1'b0;
            else if (i_set)
                i_next = 1'b1;
        end
    end

    // Flag registers and the interrupt entry sequencer.
    // IDLE looks at the registered I, so a RETIE committing this cycle
    // cannot start an entry until the following cycle.
    // Once DRAIN is reached, entry completes even if intr drops.
    // Stall and redirect are registered from the state being entered,
    // so they line up exactly with DRAIN/ENTER.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            c_flag       <= 1'b0;
            z_flag       <= 1'b0;
            i_flag       <= 1'b0;
            shad_c       <= 1'b0;
            shad_z       <= 1'b0;
            int_stall    <= 1'b0;
            int_redirect <= 1'b0;
        end else begin
            c_flag <= c_next;
            z_flag <= z_next;
            i_flag <= i_next;

            if (entering) begin
                shad_c <= c_flag;
                shad_z <= z_flag;
            end

            case (state)
                IDLE: begin
                    if (intr && i_flag) begin
                        state        <= DRAIN;
                        int_stall    <= 1'b1;
                        int_redirect <= 1'b0;
                    end else begin
                        state        <= IDLE;
                        int_stall    <= 1'b0;
                        int_redirect <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (pipe_drained) begin
                        state        <= ENTER;
                        int_stall    <= 1'b1;
                        int_redirect <= 1'b1;
                    end else begin
                        state        <= DRAIN;
                        int_stall    <= 1'b1;
                        int_redirect <= 1'b0;
                    end
                end
                ENTER: begin
                    state        <= IDLE;
                    int_stall    <= 1'b0;
                    int_redirect <= 1'b0;
                end
                default: begin
                    state        <= IDLE;
                    int_stall    <= 1'b0;
                    int_redirect <= 1'b0;
                end
            endcase
        end
    end

`ifdef FLAG_BYPASS_EN
    // Forward the update happening this cycle, so a branch issued right
    // after the flag-writing op sees the new value without a stall.
    assign c_out = c_next;
    assign z_out = z_next;
`else
    // Registered flags only. The hazard unit must put one stall between
    // a flag write and a branch that depends on it.
    assign c_out = c_flag;
    assign z_out = z_flag;
`endif

    assign i_out          = i_flag;
    assign int_vector_out = INT_VECTOR;

endmodule

// File: tb/tb_flag_interrupt_unit.sv
// tb_flag_interrupt_unit
//
// Scoreboard bench for flag_interrupt_unit.
//
// The driver applies one input vector per cycle, on the falling edge. For
// each vector, a behavioural reference model works out what the outputs
// should be after the next rising edge, and pushes that result into a queue.
// A separate monitor pops one entry per cycle, just after the rising edge,
// and compares it with the DUT outputs.
//
// The stimulus runs in two parts:
//   - directed sequences that follow the test plan
//   - a randomized run

module tb_flag_interrupt_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       c_in, z_in;
    logic       flg_c_ld, flg_z_ld, flg_c_set, flg_c_clr;
    logic       i_set, i_clr;
    logic       ret_commit;
    logic [3:0] branch_type;
    logic       intr, pipe_drained;
    logic       c_out, z_out, i_out, int_stall, int_redirect;
    logic [9:0] int_vector_out;

    always #5 clk = ~clk;

    flag_interrupt_unit #(.PC_WIDTH(10), .INT_VECTOR(10'h3FF)) dut (
        .clk(clk), .rst_n(rst_n), .c_in(c_in), .z_in(z_in),
        .flg_c_ld(flg_c_ld), .flg_z_ld(flg_z_ld),
        .flg_c_set(flg_c_set), .flg_c_clr(flg_c_clr),
        .i_set(i_set), .i_clr(i_clr), .ret_commit(ret_commit),
        .branch_type(branch_type), .intr(intr), .pipe_drained(pipe_drained),
        .c_out(c_out), .z_out(z_out), .i_out(i_out),
        .int_stall(int_stall), .int_redirect(int_redirect),
        .int_vector_out(int_vector_out)
    );

    typedef struct {
        bit       rst_n, c_in, z_in, c_ld, z_ld, c_set, c_clr;
        bit       i_set, i_clr, ret;
        bit [3:0] bt;
        bit       intr, pd;
    } stim_t;

    typedef struct {
        bit c, z, i, stall, redirect;
    } exp_t;

    exp_t expQ[$];
    int   checks = 0;
    int   fails  = 0;

    // Reference model state. The interrupt entry is tracked as a phase:
    //   "none"     : no entry under way
    //   "waiting"  : waiting for the pipeline to drain
    //   "vectoring": the redirect cycle
    bit    mC, mZ, mI, mShC, mShZ;
    string mPhase = "none";

    // Model of one rising edge, computed from the flag and interrupt rules.
    task automatic modelStep(input stim_t s);
        bit restore, vectoring;
        bit nC, nZ, nI;
        if (!s.rst_n) begin
            {mC, mZ, mI, mShC, mShZ} = 5'b0;
            mPhase = "none";
            return;
        end
        restore   = s.ret && (s.bt == 4'd8 || s.bt == 4'd9);
        vectoring = (mPhase == "vectoring");
        nC = mC;
        nZ = mZ;
        nI = mI;
        if (vectoring) begin
            nI   = 0;
            mShC = mC;
            mShZ = mZ;
        end else begin
            nC = restore ? mShC : s.c_clr ? 1'b0 : s.c_set ? 1'b1 : s.c_ld ? s.c_in : mC;
            nZ = restore ? mShZ : s.z_ld ? s.z_in : mZ;
            if (restore)      nI = (s.bt == 4'd9);
            else if (s.i_clr) nI = 0;
            else if (s.i_set) nI = 1;
        end
        if (mPhase == "none")
            mPhase = (s.intr && mI) ? "waiting" : "none";
        else if (mPhase == "waiting")
            mPhase = s.pd ? "vectoring" : "waiting";
        else
            mPhase = "none";
        mC = nC;
        mZ = nZ;
        mI = nI;
    endtask

    // Drive one input vector and queue the outputs expected after the next edge.
    task automatic applyStimulus(input stim_t s);
        exp_t e;
        @(negedge clk);
        rst_n        = s.rst_n;
        c_in         = s.c_in;
        z_in         = s.z_in;
        flg_c_ld     = s.c_ld;
        flg_z_ld     = s.z_ld;
        flg_c_set    = s.c_set;
        flg_c_clr    = s.c_clr;
        i_set        = s.i_set;
        i_clr        = s.i_clr;
        ret_commit   = s.ret;
        branch_type  = s.bt;
        intr         = s.intr;
        pipe_drained = s.pd;
        modelStep(s);
        e.c        = mC;
        e.z        = mZ;
        e.i        = mI;
        e.stall    = (mPhase != "none");
        e.redirect = (mPhase == "vectoring");
        expQ.push_back(e);
    endtask

    task automatic checkBit(input string name, input bit act, input bit req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("[TB] FAIL %s at %0t: got %0b, expected %0b", name, $time, act, req);
        end
    endtask

    task automatic checkOutput(input exp_t e);
        checkBit("c_out", c_out, e.c);
        checkBit("z_out", z_out, e.z);
        checkBit("i_out", i_out, e.i);
        checkBit("int_stall", int_stall, e.stall);
        checkBit("int_redirect", int_redirect, e.redirect);
        checks++;
        if (int_vector_out !== 10'h3FF) begin
            fails++;
            $display("[TB] FAIL int_vector_out at %0t: got %h, expected 3ff", $time, int_vector_out);
        end
    endtask

    function automatic stim_t quiet();
        stim_t s;
        s       = '{default: 0};
        s.rst_n = 1;
        return s;
    endfunction

    // The monitor compares one queued expectation per cycle, just after the edge.
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput(e);
            end
        end
    end

    initial begin : driver
        stim_t s;

        // Reset with every other input held high.
        s        = '{default: 1};
        s.rst_n  = 0;
        s.bt     = 4'hF;
        applyStimulus(s);

        // C priority: CLR beats SET and LD.
        s       = quiet();
        s.c_clr = 1;
        s.c_set = 1;
        s.c_ld  = 1;
        s.c_in  = 1;
        applyStimulus(s);

        // I = 1, C = 1, Z = 0.
        s       = quiet();
        s.i_set = 1;
        s.c_set = 1;
        s.z_ld  = 1;
        s.z_in  = 0;
        applyStimulus(s);

        // Interrupt entry: pipe not drained for 3 cycles, then drained.
        s      = quiet();
        s.intr = 1;
        applyStimulus(s);
        for (int k = 0; k < 3; k++)
            applyStimulus(s);
        s.pd = 1;
        applyStimulus(s);
        s = quiet();
        for (int k = 0; k < 3; k++)
            applyStimulus(s);

        // Load C = 0, Z = 1, then RETIE restores C = 1, Z = 0, I = 1.
        s      = quiet();
        s.c_ld = 1;
        s.c_in = 0;
        s.z_ld = 1;
        s.z_in = 1;
        applyStimulus(s);
        s     = quiet();
        s.ret = 1;
        s.bt  = 4'd9;
        applyStimulus(s);

        // Same again with RETID, which leaves I cleared.
        s      = quiet();
        s.c_ld = 1;
        s.c_in = 0;
        s.z_ld = 1;
        s.z_in = 1;
        applyStimulus(s);
        s     = quiet();
        s.ret = 1;
        s.bt  = 4'd8;
        applyStimulus(s);

        // A plain RET (7) changes no flags.
        s     = quiet();
        s.ret = 1;
        s.bt  = 4'd7;
        applyStimulus(s);

        // Masked interrupt for 10 cycles, then SEI lets it in.
        s      = quiet();
        s.intr = 1;
        for (int k = 0; k < 10; k++)
            applyStimulus(s);
        s.i_set = 1;
        applyStimulus(s);
        s.i_set = 0;
        applyStimulus(s);
        applyStimulus(s);

        // Reset while in DRAIN, then no redirect even with the pipe drained.
        s       = quiet();
        s.rst_n = 0;
        applyStimulus(s);
        s    = quiet();
        s.pd = 1;
        for (int k = 0; k < 5; k++)
            applyStimulus(s);

        // Randomized run.
        for (int n = 0; n < 3000; n++) begin
            s       = quiet();
            s.rst_n = ($urandom_range(0, 99) != 0);
            s.c_in  = 1'($urandom);
            s.z_in  = 1'($urandom);
            s.c_ld  = ($urandom_range(0, 2) == 0);
            s.z_ld  = ($urandom_range(0, 2) == 0);
            s.c_set = ($urandom_range(0, 7) == 0);
            s.c_clr = ($urandom_range(0, 7) == 0);
            s.i_set = ($urandom_range(0, 5) == 0);
            s.i_clr = ($urandom_range(0, 9) == 0);
            s.ret   = ($urandom_range(0, 7) == 0);
            case ($urandom_range(0, 3))
                0:       s.bt = 4'd7;
                1:       s.bt = 4'd8;
                2:       s.bt = 4'd9;
                default: s.bt = 4'($urandom);
            endcase
            s.intr = ($urandom_range(0, 2) != 0);
            s.pd   = ($urandom_range(0, 2) == 0);
            applyStimulus(s);
        end

        // Let the monitor consume the remaining expectations (bounded wait).
        for (int k = 0; k < 10 && expQ.size() > 0; k++)
            @(posedge clk);
        #2;
        checks++;
        if (expQ.size() != 0) begin
            fails++;
            $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0", expQ.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
